// File: rtl/gate_pkg.sv
// Shared definitions for the basic-gate exerciser: gate bit positions, FSM states
// and the reference model used to judge the gate unit's outputs.
package gate_pkg;

    localparam int AND       = 0;
    localparam int OR        = 1;
    localparam int NOT_A     = 2;
    localparam int XOR       = 3;
    localparam int XNOR      = 4;
    localparam int NAND      = 5;
    localparam int NUM_GATES = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } gx_state_t;

    function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
        logic [NUM_GATES-1:0] g;
        g        = '0;
        g[AND]   = a & b;
        g[OR]    = a | b;
        g[NOT_A] = ~a;
        g[XOR]   = a ^ b;
        g[XNOR]  = ~(a ^ b);
        g[NAND]  = ~(a & b);
        return g;
    endfunction

endpackage

// File: rtl/gate_exerciser.sv
// Walks the four (a,b) vectors through the gate unit, compares each returned word
// against the package reference model and reports pass / error count / fail mask.
//   state  | meaning
//   IDLE   | waiting for start; results held from previous run
//   SETTLE | current vector driven, counting settle cycles
//   CHECK  | gates_i compared and accumulated at the closing edge
//   DONE   | one-cycle done pulse, pass published
module gate_exerciser
    import gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a_o,
    output logic                 b_o,
    input  logic [NUM_GATES-1:0] gates_i,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2:0]           err_count,
    output logic [NUM_GATES-1:0] fail_mask
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    gx_state_t            r_state;
    logic [1:0]           r_vec;
    logic [CNT_W-1:0]     r_cnt;

    logic [NUM_GATES-1:0] w_mis;
    logic [2:0]           w_err_next;
    logic [1:0]           w_vec_next;

    assign w_mis      = gates_i ^ expected_gates(a_o, b_o);
    assign w_err_next = (w_mis != '0) ? err_count + 3'd1 : err_count;
    assign w_vec_next = r_vec + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_vec     <= 2'd0;
            r_cnt     <= '0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= SETTLE;
                        r_vec     <= 2'd0;
                        r_cnt     <= '0;
                        a_o       <= 1'b0;
                        b_o       <= 1'b0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_count <= 3'd0;
                        fail_mask <= '0;
                    end
                end
                SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    fail_mask <= fail_mask | w_mis;
                    err_count <= w_err_next;
                    if (r_vec == 2'd3) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        pass    <= (w_err_next == 3'd0);
                        a_o     <= 1'b0;
                        b_o     <= 1'b0;
                    end else begin
                        r_state <= SETTLE;
                        r_vec   <= w_vec_next;
                        r_cnt   <= '0;
                        a_o     <= w_vec_next[1];
                        b_o     <= w_vec_next[0];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
